isp_frame_ctrl: RTL and testbench

Frame sequencer between the raw-pixel input FIFO and the ISP pipeline inside the AHB ISP subsystem. It pops pixels from a first-word-fall-through FIFO, frames them into lines and frames using the AHB-programmed geometry, and inserts programmable horizontal blanking between lines so line buffers can drain. It counts completed frames and raises a frame-done pulse for the register block.

---
 rtl/isp_pkg.sv | 17 +
 rtl/isp_xy_counter.sv | 55 +++++
 rtl/isp_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_isp_frame_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared definitions for the ISP frame sequencer and its timing helpers.
package isp_pkg;

    localparam int PIX_W = 16;  // pixel word, 12-bit raw MSB-aligned
    localparam int XW    = 12;  // column counter / line width
    localparam int YW    = 12;  // row counter / frame height
    localparam int BW    = 8;   // horizontal-blank counter
    localparam int FCW   = 16;  // frame counter / frame limit

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LINE   = 2'd1,
        ST_HBLANK = 2'd2,
        ST_FEND   = 2'd3
    } isp_state_e;

endpackage

// File: rtl/isp_xy_counter.sv
// Column/row position counter with wrap and last-column/last-row flags.
// The counter wraps both coordinates back to 0 after the last pixel of a
// frame, so a back-to-back frame starts at the origin without extra logic.
module isp_xy_counter
    import isp_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,     // force x=0,y=0 (wins over step_i)
    input  logic          step_i,      // advance by one pixel
    input  logic [XW-1:0] width_i,
    input  logic [YW-1:0] height_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_col_o,
    output logic          last_row_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign last_col_o = (x_q == width_i - XW'(1));
    assign last_row_o = (y_q == height_i - YW'(1));
    assign x_o        = x_q;
    assign y_o        = y_q;

    // Next position: clear, or step with column wrap feeding the row.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (step_i) begin
            if (last_col_o) begin
                x_d = '0;
                y_d = last_row_o ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/isp_frame_ctrl.sv
// Frame sequencer: pops pixels from an FWFT FIFO, frames them into lines and
// frames using shadowed geometry, inserts horizontal blanking between lines
// and counts completed frames.
//
// Handshake: the FIFO side is FWFT. fifo_rdata is valid whenever fifo_empty
// is low, and a word is consumed on every clock edge where fifo_rd is high;
// fifo_rd is only ever raised while fifo_empty is low. The pixel side has no
// backpressure: pix_data and the pix_* flags are meaningful only in cycles
// where pix_valid is high, and each pix_valid cycle carries exactly one pixel.
module isp_frame_ctrl
    import isp_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             cfg_enable,
    input  logic             cfg_abort,
    input  logic [XW-1:0]    cfg_width,
    input  logic [YW-1:0]    cfg_height,
    input  logic [BW-1:0]    cfg_hblank,
    input  logic [FCW-1:0]   cfg_nframes,
    input  logic             fifo_empty,
    input  logic [PIX_W-1:0] fifo_rdata,
    output logic             fifo_rd,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_eof,
    output logic [XW-1:0]    pix_x,
    output logic [YW-1:0]    pix_y,
    output logic             busy,
    output logic [FCW-1:0]   frames_cnt,
    output logic             frame_done,
    output logic             cfg_err,
    output isp_state_e       dbg_state
);

    isp_state_e       state_q;
    logic             busy_q;
    logic [XW-1:0]    width_q;
    logic [YW-1:0]    height_q;
    logic [BW-1:0]    hblank_q;
    logic [FCW-1:0]   nframes_q;
    logic [BW-1:0]    bcnt_q;
    logic [FCW-1:0]   frames_cnt_q;
    logic             frame_done_q;
    logic             cfg_err_q;

    logic [PIX_W-1:0] pix_data_q;
    logic             pix_valid_q;
    logic             pix_sof_q;
    logic             pix_eol_q;
    logic             pix_eof_q;
    logic [XW-1:0]    pix_x_q;
    logic [YW-1:0]    pix_y_q;

    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic             last_col;
    logic             last_row;
    logic             fifo_rd_w;
    logic             geom_ok;
    logic [FCW-1:0]   frames_nxt;
    logic             run_on;
    logic             xy_clear;

    // Pop whenever a line is in progress and the FIFO has a word.
    assign fifo_rd_w  = (state_q == ST_LINE) && !fifo_empty;
    assign geom_ok    = (cfg_width != '0) && (cfg_height != '0);
    assign frames_nxt = frames_cnt_q + FCW'(1);
    assign run_on     = cfg_enable && ((nframes_q == '0) || (frames_nxt != nframes_q));
    // Counter restarts at every frame start (from IDLE or back-to-back).
    assign xy_clear   = !cfg_abort &&
                        (((state_q == ST_IDLE) && cfg_enable && geom_ok) ||
                         ((state_q == ST_FEND) && run_on));

    isp_xy_counter u_xy (
        .clk_i      (HCLK),
        .rst_ni     (HRESETn),
        .clear_i    (xy_clear),
        .step_i     (fifo_rd_w),
        .width_i    (width_q),
        .height_i   (height_q),
        .x_o        (x),
        .y_o        (y),
        .last_col_o (last_col),
        .last_row_o (last_row)
    );

    // Frame FSM with shadow geometry, blank counter, frame counter and status.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            width_q      <= '0;
            height_q     <= '0;
            hblank_q     <= '0;
            nframes_q    <= '0;
            bcnt_q       <= '0;
            frames_cnt_q <= '0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!cfg_enable) begin
                cfg_err_q <= 1'b0;
            end
            if (cfg_abort) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cfg_enable) begin
                            if (geom_ok) begin
                                width_q      <= cfg_width;
                                height_q     <= cfg_height;
                                hblank_q     <= cfg_hblank;
                                nframes_q    <= cfg_nframes;
                                frames_cnt_q <= '0;
                                state_q      <= ST_LINE;
                                busy_q       <= 1'b1;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    ST_LINE: begin
                        if (fifo_rd_w && last_col) begin
                            if (last_row) begin
                                state_q <= ST_FEND;
                            end else if (hblank_q != '0) begin
                                state_q <= ST_HBLANK;
                                bcnt_q  <= hblank_q - BW'(1);
                            end
                        end
                    end
                    ST_HBLANK: begin
                        if (bcnt_q == '0) begin
                            state_q <= ST_LINE;
                        end else begin
                            bcnt_q <= bcnt_q - BW'(1);
                        end
                    end
                    ST_FEND: begin
                        frames_cnt_q <= frames_nxt;
                        frame_done_q <= 1'b1;
                        if (run_on) begin
                            width_q   <= cfg_width;
                            height_q  <= cfg_height;
                            hblank_q  <= cfg_hblank;
                            nframes_q <= cfg_nframes;
                            state_q   <= ST_LINE;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // One-cycle output pipeline; flags are gated by the pop so they are 0 when not valid.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_sof_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_eof_q   <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
        end else begin
            pix_data_q  <= fifo_rdata;
            pix_valid_q <= fifo_rd_w;
            pix_sof_q   <= fifo_rd_w && (x == '0) && (y == '0);
            pix_eol_q   <= fifo_rd_w && last_col;
            pix_eof_q   <= fifo_rd_w && last_col && last_row;
            pix_x_q     <= x;
            pix_y_q     <= y;
        end
    end

    assign fifo_rd    = fifo_rd_w;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_sof    = pix_sof_q;
    assign pix_eol    = pix_eol_q;
    assign pix_eof    = pix_eof_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign busy       = busy_q;
    assign frames_cnt = frames_cnt_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_isp_frame_ctrl.sv
// Self-checking bench for isp_frame_ctrl: a pixel-index model predicts every
// output each cycle, a scoreboard queue tracks popped FIFO words, and each
// directed scenario also pins a few hand-computed totals.
module tb_isp_frame_ctrl;
  import isp_pkg::*;

  // ---------------- clock / reset ----------------
  logic HCLK;
  logic HRESETn;
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // ---------------- DUT signals ----------------
  logic             cfg_enable;
  logic             cfg_abort;
  logic [XW-1:0]    cfg_width;
  logic [YW-1:0]    cfg_height;
  logic [BW-1:0]    cfg_hblank;
  logic [FCW-1:0]   cfg_nframes;
  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_rdata;
  logic             fifo_rd;
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_sof;
  logic             pix_eol;
  logic             pix_eof;
  logic [XW-1:0]    pix_x;
  logic [YW-1:0]    pix_y;
  logic             busy;
  logic [FCW-1:0]   frames_cnt;
  logic             frame_done;
  logic             cfg_err;
  isp_state_e       dbg_state;

  isp_frame_ctrl dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cfg_enable  (cfg_enable),
    .cfg_abort   (cfg_abort),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .cfg_hblank  (cfg_hblank),
    .cfg_nframes (cfg_nframes),
    .fifo_empty  (fifo_empty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rd     (fifo_rd),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .busy        (busy),
    .frames_cnt  (frames_cnt),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
  endtask

  // ---------------- FIFO source ----------------
  logic [PIX_W-1:0] src_q[$];
  int  empty_mode = 0;   // 0: never empty, 1: toggles each cycle, 2: random
  logic rd_seen = 1'b0;  // DUT pop strobe sampled on the falling edge

  // ---------------- behavioural model ----------------
  // A frame is a run of width*height pops indexed by m_pix; position is
  // derived with / and %. Blanking and the end-of-frame cycle are counted
  // in plain integers.
  int m_run = 0, m_fend = 0, m_blank = 0, m_pix = 0, m_frames = 0, m_err = 0;
  int sw = 0, sh = 0, sb = 0, sn = 0;
  int e_valid = 0, e_sof = 0, e_eol = 0, e_eof = 0, e_x = 0, e_y = 0;
  int e_busy = 0, e_frames = 0, e_done = 0, e_err = 0;
  logic [PIX_W-1:0] exp_q[$];

  function automatic int model_rd();
    return (m_run != 0 && m_fend == 0 && m_blank == 0 && !fifo_empty) ? 1 : 0;
  endfunction

  // Model step and FIFO source update on every rising edge.
  always @(posedge HCLK) begin
    int rd;
    if (!HRESETn) begin
      m_run = 0; m_fend = 0; m_blank = 0; m_pix = 0; m_frames = 0; m_err = 0;
      e_valid = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_x = 0; e_y = 0;
      e_busy = 0; e_frames = 0; e_done = 0; e_err = 0;
      exp_q.delete();
    end else begin
      rd = model_rd();
      e_valid = rd;
      e_sof = 0; e_eol = 0; e_eof = 0;
      if (rd != 0) begin
        exp_q.push_back(src_q[0]);
        e_x   = m_pix % sw;
        e_y   = m_pix / sw;
        e_sof = (m_pix == 0) ? 1 : 0;
        e_eol = ((m_pix % sw) == sw - 1) ? 1 : 0;
        e_eof = (m_pix == sw * sh - 1) ? 1 : 0;
      end
      e_done = 0;
      if (cfg_abort) begin
        m_run = 0; m_fend = 0; m_blank = 0;
      end else if (m_run == 0) begin
        if (cfg_enable) begin
          if (cfg_width != 0 && cfg_height != 0) begin
            sw = int'(cfg_width); sh = int'(cfg_height);
            sb = int'(cfg_hblank); sn = int'(cfg_nframes);
            m_frames = 0; m_pix = 0; m_blank = 0; m_fend = 0; m_run = 1;
          end else begin
            m_err = 1;
          end
        end
      end else if (m_fend != 0) begin
        m_frames = (m_frames + 1) % 65536;
        e_done = 1;
        m_fend = 0;
        if (cfg_enable && (sn == 0 || m_frames != sn)) begin
          sw = int'(cfg_width); sh = int'(cfg_height);
          sb = int'(cfg_hblank); sn = int'(cfg_nframes);
          m_pix = 0;
        end else begin
          m_run = 0;
        end
      end else if (m_blank > 0) begin
        m_blank--;
      end else if (rd != 0) begin
        m_pix++;
        if (m_pix == sw * sh) m_fend = 1;
        else if ((m_pix % sw) == 0 && sb != 0) m_blank = sb;
      end
      if (!cfg_enable) m_err = 0;
      e_busy = m_run; e_frames = m_frames; e_err = m_err;
    end
    if (rd_seen && !fifo_empty && src_q.size() > 0) void'(src_q.pop_front());
    #1;
    while (src_q.size() < 4) src_q.push_back(PIX_W'($urandom_range(0, 65535)));
    fifo_rdata = src_q[0];
    case (empty_mode)
      0:       fifo_empty = 1'b0;
      1:       fifo_empty = ~fifo_empty;
      default: fifo_empty = ($urandom_range(0, 3) == 0);
    endcase
  end

  // ---------------- per-cycle compare + event tallies ----------------
  int cyc = 0;
  int valid_cnt = 0, sof_cnt = 0, eol_cnt = 0, eof_cnt = 0, done_cnt = 0, all3_cnt = 0;
  int sof_cyc = 0, eof_cyc = 0;

  always @(negedge HCLK) begin
    logic [PIX_W-1:0] d;
    cyc++;
    rd_seen = fifo_rd;
    if (HRESETn) begin
      chk("fifo_rd",    32'(fifo_rd),    32'(model_rd()));
      chk("pix_valid",  32'(pix_valid),  32'(e_valid));
      chk("pix_sof",    32'(pix_sof),    32'(e_sof));
      chk("pix_eol",    32'(pix_eol),    32'(e_eol));
      chk("pix_eof",    32'(pix_eof),    32'(e_eof));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("frames_cnt", 32'(frames_cnt), 32'(e_frames));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("cfg_err",    32'(cfg_err),    32'(e_err));
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL pix_data: got %0h expected no pixel (t=%0t)", pix_data, $time);
        end else begin
          d = exp_q.pop_front();
          chk("pix_data", 32'(pix_data), 32'(d));
        end
        chk("pix_x", 32'(pix_x), 32'(e_x));
        chk("pix_y", 32'(pix_y), 32'(e_y));
        valid_cnt++;
        if (pix_sof) begin sof_cnt++; sof_cyc = cyc; end
        if (pix_eol) eol_cnt++;
        if (pix_eof) begin eof_cnt++; eof_cyc = cyc; end
        if (pix_sof && pix_eol && pix_eof) all3_cnt++;
      end
      if (frame_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic set_cfg(input int w, input int h, input int b, input int n);
    cfg_width   = XW'(w);
    cfg_height  = YW'(h);
    cfg_hblank  = BW'(b);
    cfg_nframes = FCW'(n);
  endtask

  task automatic wait_done(input string name, input int bound);
    int got = 0;
    for (int k = 0; k < bound; k++) begin
      tick(1);
      if (frame_done) begin got = 1; break; end
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int got = 0;
    for (int k = 0; k < bound; k++) begin
      tick(1);
      if (!busy) begin got = 1; break; end
    end
    chk({name, "_idle_seen"}, 32'(got), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int b_valid, b_sof, b_eol, b_eof, b_done, b_all3;

  task automatic snap();
    b_valid = valid_cnt; b_sof = sof_cnt; b_eol = eol_cnt;
    b_eof = eof_cnt; b_done = done_cnt; b_all3 = all3_cnt;
  endtask

  initial begin
    HRESETn = 1'b0;
    cfg_enable = 1'b0;
    cfg_abort = 1'b0;
    set_cfg(0, 0, 0, 0);
    tick(3);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_pix_valid",  32'(pix_valid),  32'd0);
    chk("rst_fifo_rd",    32'(fifo_rd),    32'd0);
    chk("rst_frames_cnt", 32'(frames_cnt), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_cfg_err",    32'(cfg_err),    32'd0);
    chk("rst_state",      32'(dbg_state),  32'(ST_IDLE));
    HRESETn = 1'b1;
    tick(2);

    // 4x2 frame, 3 blank cycles, one frame, FIFO always full.
    empty_mode = 0;
    set_cfg(4, 2, 3, 1);
    snap();
    cfg_enable = 1'b1;
    wait_done("t1", 200);
    cfg_enable = 1'b0;
    tick(3);
    chk("t1_valid",  32'(valid_cnt - b_valid), 32'd8);
    chk("t1_sof",    32'(sof_cnt - b_sof),     32'd1);
    chk("t1_eol",    32'(eol_cnt - b_eol),     32'd2);
    chk("t1_eof",    32'(eof_cnt - b_eof),     32'd1);
    chk("t1_done",   32'(done_cnt - b_done),   32'd1);
    chk("t1_span",   32'(eof_cyc - sof_cyc),   32'd10);
    chk("t1_frames", 32'(frames_cnt),          32'd1);
    chk("t1_busy",   32'(busy),                32'd0);

    // Same geometry, FIFO empty every other cycle.
    empty_mode = 1;
    snap();
    cfg_enable = 1'b1;
    wait_done("t2", 300);
    cfg_enable = 1'b0;
    tick(3);
    chk("t2_valid", 32'(valid_cnt - b_valid), 32'd8);
    chk("t2_eol",   32'(eol_cnt - b_eol),     32'd2);
    chk("t2_eof",   32'(eof_cnt - b_eof),     32'd1);

    // Continuous 2x2, enable dropped inside frame 2: frame 2 still completes.
    empty_mode = 0;
    set_cfg(2, 2, 2, 0);
    snap();
    cfg_enable = 1'b1;
    wait_done("t3a", 200);
    tick(2);
    cfg_enable = 1'b0;
    wait_idle("t3", 200);
    tick(2);
    chk("t3_frames", 32'(frames_cnt),        32'd2);
    chk("t3_eof",    32'(eof_cnt - b_eof),   32'd2);
    chk("t3_done",   32'(done_cnt - b_done), 32'd2);

    // 4x4 continuous: abort during row 1 of frame 2.
    set_cfg(4, 4, 1, 0);
    cfg_enable = 1'b1;
    wait_done("t4a", 300);
    begin
      int got = 0;
      for (int k = 0; k < 100; k++) begin
        tick(1);
        if (pix_valid && pix_y == YW'(1)) begin got = 1; break; end
      end
      chk("t4_row1_seen", 32'(got), 32'd1);
    end
    snap();
    cfg_abort = 1'b1;
    cfg_enable = 1'b0;
    tick(1);
    cfg_abort = 1'b0;
    tick(2);
    chk("t4_busy",   32'(busy),                32'd0);
    chk("t4_frames", 32'(frames_cnt),          32'd1);
    chk("t4_eof",    32'(eof_cnt - b_eof),     32'd0);
    chk("t4_done",   32'(done_cnt - b_done),   32'd0);
    tick(2);

    // Zero width refused.
    set_cfg(0, 2, 0, 0);
    cfg_enable = 1'b1;
    tick(3);
    chk("t5_err",  32'(cfg_err), 32'd1);
    chk("t5_busy", 32'(busy),    32'd0);
    cfg_enable = 1'b0;
    tick(1);
    chk("t5_err_clr", 32'(cfg_err), 32'd0);

    // Width write mid-frame applies only from the next frame.
    set_cfg(4, 2, 0, 2);
    snap();
    cfg_enable = 1'b1;
    tick(2);
    cfg_width = XW'(6);
    wait_done("t6a", 200);
    wait_done("t6b", 200);
    cfg_enable = 1'b0;
    tick(3);
    chk("t6_valid",  32'(valid_cnt - b_valid), 32'd20);
    chk("t6_eol",    32'(eol_cnt - b_eol),     32'd4);
    chk("t6_frames", 32'(frames_cnt),          32'd2);

    // 1x1 frame: sof, eol and eof coincide on the only pixel.
    set_cfg(1, 1, 5, 1);
    snap();
    cfg_enable = 1'b1;
    wait_done("t7", 100);
    cfg_enable = 1'b0;
    tick(3);
    chk("t7_valid", 32'(valid_cnt - b_valid), 32'd1);
    chk("t7_all3",  32'(all3_cnt - b_all3),   32'd1);

    // Randomised geometry, FIFO behaviour and mid-frame width writes.
    for (int it = 0; it < 10; it++) begin
      int n;
      empty_mode = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      set_cfg($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(0, 3), n);
      cfg_enable = 1'b1;
      tick(3);
      cfg_width = XW'($urandom_range(1, 5));
      for (int f = 0; f < n; f++) wait_done("t8", 600);
      cfg_enable = 1'b0;
      tick(4);
    end

    tick(5);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
